// File: rtl/camera_frame_latch_if.sv
// Shared fixed-point types/arithmetic and the camera snapshot bus.
//   camera_frame_latch_pkg : fp (signed Q3.12), vec3, fp_add/fp_sub/fp_mul/fp_neg
//   camera_frame_latch_if  : live pose/mode inputs + frame request (master drives),
//                            frame-stable outputs + status (slave drives)
package camera_frame_latch_pkg;
    localparam int FP_FRAC = 12;

    typedef logic signed [15:0] fp;
    typedef struct packed {
        fp x;
        fp y;
        fp z;
    } vec3;

    localparam fp FP_ZERO        = 16'sd0;
    localparam fp FP_HALF        = 16'sd2048;
    localparam fp FP_ONE         = 16'sd4096;
    localparam fp FP_THREE_HALFS = 16'sd6144;
    localparam fp FP_THREE       = 16'sd12288;

    // Wrapping add/sub; multiply truncates toward minus infinity.
    function automatic fp fp_add(input fp a, input fp b);
        return a + b;
    endfunction

    function automatic fp fp_sub(input fp a, input fp b);
        return a - b;
    endfunction

    function automatic fp fp_neg(input fp a);
        return -a;
    endfunction

    function automatic fp fp_mul(input fp a, input fp b);
        logic signed [31:0] p;
        p = 32'(a) * 32'(b);
        return p[FP_FRAC+15:FP_FRAC];
    endfunction
endpackage

interface camera_frame_latch_if
    import camera_frame_latch_pkg::*;
    #(parameter int FRAME_CNT_BITS = 16) ();

    vec3                      pos_in;
    vec3                      dir_in;
    logic [2:0]               fractal_sel_in;
    logic [3:0]               toggles_in;
    logic                     frame_req_in;

    vec3                      pos_out;
    vec3                      dir_out;
    logic [2:0]               fractal_sel_out;
    logic [3:0]               toggles_out;
    logic                     frame_valid_out;
    logic                     busy_out;
    logic                     renorm_skip_out;
    logic [FRAME_CNT_BITS-1:0] frame_cnt_out;

    modport master (
        output pos_in, dir_in, fractal_sel_in, toggles_in, frame_req_in,
        input  pos_out, dir_out, fractal_sel_out, toggles_out,
               frame_valid_out, busy_out, renorm_skip_out, frame_cnt_out
    );

    modport slave (
        input  pos_in, dir_in, fractal_sel_in, toggles_in, frame_req_in,
        output pos_out, dir_out, fractal_sel_out, toggles_out,
               frame_valid_out, busy_out, renorm_skip_out, frame_cnt_out
    );
endinterface

// File: rtl/camera_frame_latch.sv
// Frame-boundary latch for camera pose and render-mode switches.
// Captures the live inputs when the renderer requests a frame, renormalises the
// view direction with one Newton step (k = (3 - |d|^2) / 2, d' = d * k) using a
// single shared multiplier, then commits everything to the outputs on one edge.
//
// Ports:
//   clk_in : system clock
//   rst_in : synchronous reset, active-high
//   bus    : camera_frame_latch_if.slave (live inputs, frame-stable outputs, status)
//
// state | meaning
// IDLE  | waiting for frame_req_in; captures inputs on request
// SQX   | acc = x*x
// SQY   | acc += y*y
// SQZ   | acc += z*z
// KCALC | k = (3 - acc) / 2, or bypass (k = 1) when acc is 0 or >= 3
// MX    | x = x*k
// MY    | y = y*k
// MZ    | z = z*k; commit snapshot to outputs
// DONE  | valid pulse cycle; request not sampled
module camera_frame_latch
    import camera_frame_latch_pkg::*;
    #(
        parameter bit RENORM_EN      = 1'b1,
        parameter int FRAME_CNT_BITS = 16
    ) (
        input logic            clk_in,
        input logic            rst_in,
        camera_frame_latch_if.slave bus
    );

    localparam vec3 POS_RST = {FP_ZERO, FP_ONE, fp_neg(FP_THREE_HALFS)};
    localparam vec3 DIR_RST = {FP_ZERO, FP_ZERO, FP_ONE};

    typedef enum logic [3:0] {
        IDLE, SQX, SQY, SQZ, KCALC, MX, MY, MZ, DONE
    } state_t;

    state_t state, state_nxt;

    vec3                       snap_pos, snap_dir;
    logic [2:0]                snap_sel;
    logic [3:0]                snap_tog;
    fp                         acc, k;
    logic                      skip;

    vec3                       pos_q, dir_q;
    logic [2:0]                sel_q;
    logic [3:0]                tog_q;
    logic                      valid_q, skip_q;
    logic [FRAME_CNT_BITS-1:0] cnt_q;

    fp    mul_a, mul_b, mul_p;
    logic k_bypass;

    // A zero or too-large magnitude would make the Newton step diverge.
    assign k_bypass = (acc == FP_ZERO) || (acc >= FP_THREE);
    assign mul_p    = fp_mul(mul_a, mul_b);

    always_ff @(posedge clk_in) begin
        if (rst_in) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        mul_a     = FP_ZERO;
        mul_b     = FP_ZERO;
        case (state)
            IDLE:  if (bus.frame_req_in) state_nxt = RENORM_EN ? SQX : DONE;
            SQX:   begin state_nxt = SQY; mul_a = snap_dir.x; mul_b = snap_dir.x; end
            SQY:   begin state_nxt = SQZ; mul_a = snap_dir.y; mul_b = snap_dir.y; end
            SQZ:   begin state_nxt = KCALC; mul_a = snap_dir.z; mul_b = snap_dir.z; end
            KCALC: begin
                state_nxt = k_bypass ? MZ : MX;
                mul_a     = fp_sub(FP_THREE, acc);
                mul_b     = FP_HALF;
            end
            MX:    begin state_nxt = MY; mul_a = snap_dir.x; mul_b = k; end
            MY:    begin state_nxt = MZ; mul_a = snap_dir.y; mul_b = k; end
            MZ:    begin state_nxt = DONE; mul_a = snap_dir.z; mul_b = k; end
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            snap_pos <= POS_RST;
            snap_dir <= DIR_RST;
            snap_sel <= '0;
            snap_tog <= '0;
            acc      <= FP_ZERO;
            k        <= FP_ONE;
            skip     <= 1'b0;
            pos_q    <= POS_RST;
            dir_q    <= DIR_RST;
            sel_q    <= '0;
            tog_q    <= '0;
            valid_q  <= 1'b0;
            skip_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.frame_req_in) begin
                        snap_pos <= bus.pos_in;
                        snap_dir <= bus.dir_in;
                        snap_sel <= bus.fractal_sel_in;
                        snap_tog <= bus.toggles_in;
                        skip     <= 1'b0;
                        if (!RENORM_EN) begin
                            // Without renormalisation capture and commit share an edge.
                            pos_q   <= bus.pos_in;
                            dir_q   <= bus.dir_in;
                            sel_q   <= bus.fractal_sel_in;
                            tog_q   <= bus.toggles_in;
                            valid_q <= 1'b1;
                            skip_q  <= 1'b1;
                            cnt_q   <= cnt_q + 1'b1;
                        end
                    end
                end
                SQX: acc <= mul_p;
                SQY: acc <= fp_add(acc, mul_p);
                SQZ: acc <= fp_add(acc, mul_p);
                KCALC: begin
                    if (k_bypass) begin
                        skip <= 1'b1;
                        k    <= FP_ONE;
                    end else begin
                        k    <= mul_p;
                    end
                end
                MX: snap_dir.x <= mul_p;
                MY: snap_dir.y <= mul_p;
                MZ: begin
                    snap_dir.z <= mul_p;
                    pos_q      <= snap_pos;
                    dir_q      <= {snap_dir.x, snap_dir.y, mul_p};
                    sel_q      <= snap_sel;
                    tog_q      <= snap_tog;
                    valid_q    <= 1'b1;
                    skip_q     <= skip;
                    cnt_q      <= cnt_q + 1'b1;
                end
                DONE: begin
                    valid_q <= 1'b0;
                    skip_q  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.pos_out         = pos_q;
    assign bus.dir_out         = dir_q;
    assign bus.fractal_sel_out = sel_q;
    assign bus.toggles_out     = tog_q;
    assign bus.frame_valid_out = valid_q;
    assign bus.renorm_skip_out = skip_q;
    assign bus.frame_cnt_out   = cnt_q;
    assign bus.busy_out        = (state != IDLE);

endmodule

// File: tb/tb_camera_frame_latch.sv
// Testbench for camera_frame_latch: one instance with renormalisation (16-bit
// frame counter) and one pass-through instance (4-bit counter to reach the wrap).
module tb_camera_frame_latch;
    import camera_frame_latch_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst1, rst0, req1, req0;
    vec3        pos_drv, dir_drv;
    logic [2:0] sel_drv;
    logic [3:0] tog_drv;

    camera_frame_latch_if #(.FRAME_CNT_BITS(16)) bus1 ();
    camera_frame_latch_if #(.FRAME_CNT_BITS(4))  bus0 ();

    assign bus1.pos_in         = pos_drv;
    assign bus1.dir_in         = dir_drv;
    assign bus1.fractal_sel_in = sel_drv;
    assign bus1.toggles_in     = tog_drv;
    assign bus1.frame_req_in   = req1;
    assign bus0.pos_in         = pos_drv;
    assign bus0.dir_in         = dir_drv;
    assign bus0.fractal_sel_in = sel_drv;
    assign bus0.toggles_in     = tog_drv;
    assign bus0.frame_req_in   = req0;

    camera_frame_latch #(.RENORM_EN(1'b1), .FRAME_CNT_BITS(16)) u_dut (
        .clk_in (clk),
        .rst_in (rst1),
        .bus    (bus1)
    );

    camera_frame_latch #(.RENORM_EN(1'b0), .FRAME_CNT_BITS(4)) u_dut_bypass (
        .clk_in (clk),
        .rst_in (rst0),
        .bus    (bus0)
    );

    // Observation mux: use0 selects the pass-through instance.
    logic        use0;
    vec3         o_pos, o_dir;
    logic [2:0]  o_sel;
    logic [3:0]  o_tog;
    logic        o_valid, o_busy, o_skip;
    logic [15:0] o_cnt;

    always_comb begin
        o_pos   = bus1.pos_out;
        o_dir   = bus1.dir_out;
        o_sel   = bus1.fractal_sel_out;
        o_tog   = bus1.toggles_out;
        o_valid = bus1.frame_valid_out;
        o_busy  = bus1.busy_out;
        o_skip  = bus1.renorm_skip_out;
        o_cnt   = bus1.frame_cnt_out;
        if (use0) begin
            o_pos   = bus0.pos_out;
            o_dir   = bus0.dir_out;
            o_sel   = bus0.fractal_sel_out;
            o_tog   = bus0.toggles_out;
            o_valid = bus0.frame_valid_out;
            o_busy  = bus0.busy_out;
            o_skip  = bus0.renorm_skip_out;
            o_cnt   = {12'd0, bus0.frame_cnt_out};
        end
    end

    int n_checks = 0;
    int n_errors = 0;
    int exp_cnt1 = 0;
    int exp_cnt0 = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference arithmetic: signed Q3.12, products truncated, sums wrap at 16 bits.
    function automatic shortint qm(input shortint a, input shortint b);
        int p;
        p = int'(a) * int'(b);
        return shortint'(p >>> 12);
    endfunction

    // One Newton step toward unit length; bypass when |d|^2 is 0 or >= 3.0.
    task automatic model_dir(input vec3 d, input bit en,
                             output vec3 o, output bit skip, output int lat);
        shortint s, kk;
        o    = d;
        skip = 1'b0;
        lat  = 0;
        if (en) begin
            s = shortint'(int'(qm(d.x, d.x)) + int'(qm(d.y, d.y)) + int'(qm(d.z, d.z)));
            if (s == 0 || s >= 12288) begin
                skip = 1'b1;
                lat  = 5;
            end else begin
                kk   = qm(shortint'(12288 - int'(s)), 2048);
                o    = {qm(d.x, kk), qm(d.y, kk), qm(d.z, kk)};
                lat  = 7;
            end
        end
    endtask

    function automatic vec3 rand_vec(input int span);
        vec3 v;
        v.x = fp'(int'($urandom_range(0, 2 * span)) - span);
        v.y = fp'(int'($urandom_range(0, 2 * span)) - span);
        v.z = fp'(int'($urandom_range(0, 2 * span)) - span);
        return v;
    endfunction

    task automatic set_use(input bit v);
        use0 = v;
        #1;
    endtask

    task automatic drive_req(input bit v);
        if (use0) req0 = v;
        else      req1 = v;
    endtask

    task automatic check_reset_outputs(input string tag);
        vec3 pr, dr;
        pr = {16'sd0, 16'sd4096, -16'sd6144};
        dr = {16'sd0, 16'sd0, 16'sd4096};
        check_eq({tag, "_pos"},   o_pos, pr);
        check_eq({tag, "_dir"},   o_dir, dr);
        check_eq({tag, "_sel"},   o_sel, 0);
        check_eq({tag, "_tog"},   o_tog, 0);
        check_eq({tag, "_valid"}, o_valid, 0);
        check_eq({tag, "_skip"},  o_skip, 0);
        check_eq({tag, "_cnt"},   o_cnt, 0);
        check_eq({tag, "_busy"},  o_busy, 0);
    endtask

    task automatic bump_cnt();
        if (use0) exp_cnt0 = (exp_cnt0 + 1) % 16;
        else      exp_cnt1 = (exp_cnt1 + 1) % 65536;
    endtask

    // Single requested frame; inputs are scrambled right after the capture edge.
    task automatic run_frame(input vec3 p, input vec3 d, input logic [2:0] s, input logic [3:0] t);
        vec3 ed;
        bit  eskip;
        int  elat, n;
        model_dir(d, !use0, ed, eskip, elat);
        pos_drv = p; dir_drv = d; sel_drv = s; tog_drv = t;
        drive_req(1'b1);
        @(posedge clk); @(negedge clk);
        drive_req(1'b0);
        pos_drv = rand_vec(30000); dir_drv = rand_vec(30000);
        sel_drv = 3'($urandom); tog_drv = 4'($urandom);
        n = 0;
        while (!o_valid && n < 20) begin
            @(posedge clk); @(negedge clk);
            n++;
        end
        bump_cnt();
        check_eq("latency", 64'(n), 64'(elat));
        if (o_valid) begin
            check_eq("pos", o_pos, p);
            check_eq("dir", o_dir, ed);
            check_eq("sel", o_sel, s);
            check_eq("tog", o_tog, t);
            check_eq("cnt", o_cnt, use0 ? exp_cnt0 : exp_cnt1);
            check_eq("busy_in_done", o_busy, 1);
            if (!use0) check_eq("skip", o_skip, eskip);
        end
        @(posedge clk); @(negedge clk);
        check_eq("valid_clear", o_valid, 0);
        check_eq("idle_after", o_busy, 0);
        if (!use0) check_eq("skip_clear", o_skip, 0);
    endtask

    // frame_req held high; pos changes every cycle, dir fixed at unit z.
    task automatic run_stream(input int cycles, input int period, input int lat);
        vec3 hist [0:63];
        bit  ev;
        dir_drv = {16'sd0, 16'sd0, 16'sd4096};
        sel_drv = 3'd5; tog_drv = 4'hA;
        hist[0] = rand_vec(20000);
        pos_drv = hist[0];
        drive_req(1'b1);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); @(negedge clk);
            ev = ((i % period) == lat);
            check_eq("stream_valid", o_valid, ev);
            if (ev && i >= lat) begin
                bump_cnt();
                check_eq("stream_pos", o_pos, hist[i - lat]);
                check_eq("stream_dir", o_dir, dir_drv);
                check_eq("stream_cnt", o_cnt, use0 ? exp_cnt0 : exp_cnt1);
            end
            hist[i + 1] = rand_vec(20000);
            pos_drv     = hist[i + 1];
        end
        drive_req(1'b0);
        @(posedge clk); @(negedge clk);
        check_eq("stream_end_idle", o_busy, 0);
    endtask

    task automatic directed_set();
        vec3 p;
        p = {16'sd2048, 16'sd4096, 16'sd8192};
        run_frame(p, {16'sd0, 16'sd0, 16'sd4096}, 3'd3, 4'b1010);
        run_frame(rand_vec(20000), {16'sd0, 16'sd0, 16'sd4505}, 3'd1, 4'b0101);
        run_frame(rand_vec(20000), {16'sd0, 16'sd0, 16'sd0}, 3'd7, 4'b1111);
        run_frame(rand_vec(20000), {16'sd0, 16'sd0, 16'sd8192}, 3'd2, 4'b0011);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit saw_valid;
        rst1 = 1'b1; rst0 = 1'b1; req1 = 1'b0; req0 = 1'b0;
        pos_drv = '0; dir_drv = '0; sel_drv = '0; tog_drv = '0;
        use0 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst1 = 1'b0; rst0 = 1'b0;
        set_use(1'b0);
        check_reset_outputs("rst1");
        set_use(1'b1);
        check_reset_outputs("rst0");
        set_use(1'b0);

        // Idle with random live inputs: nothing may move.
        for (int i = 0; i < 20; i++) begin
            pos_drv = rand_vec(30000); dir_drv = rand_vec(30000);
            @(posedge clk); @(negedge clk);
            check_eq("idle_quiet", {o_valid, o_busy}, 0);
        end
        check_reset_outputs("idle_hold");

        directed_set();
        for (int i = 0; i < 12; i++)
            run_frame(rand_vec(20000), rand_vec(4600), 3'($urandom), 4'($urandom));
        run_stream(36, 9, 7);

        // Reset while in MY: abort without a valid pulse.
        pos_drv = rand_vec(20000); dir_drv = {16'sd1000, 16'sd0, 16'sd4096};
        req1 = 1'b1;
        @(posedge clk); @(negedge clk);
        req1 = 1'b0;
        saw_valid = 1'b0;
        repeat (5) begin
            @(posedge clk); @(negedge clk);
            saw_valid |= o_valid;
        end
        check_eq("mid_busy", o_busy, 1);
        rst1 = 1'b1;
        @(posedge clk); @(negedge clk);
        rst1 = 1'b0;
        exp_cnt1 = 0;
        check_reset_outputs("mid_reset");
        repeat (10) begin
            @(posedge clk); @(negedge clk);
            saw_valid |= o_valid;
        end
        check_eq("mid_no_pulse", saw_valid, 0);
        run_frame(rand_vec(20000), {16'sd0, 16'sd4096, 16'sd0}, 3'd4, 4'b1001);

        // Pass-through instance.
        set_use(1'b1);
        directed_set();
        for (int i = 0; i < 4; i++)
            run_frame(rand_vec(20000), rand_vec(30000), 3'($urandom), 4'($urandom));
        run_stream(40, 2, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
